// File: rtl/bmd_256_latency_ctrl_if.sv
// Signal bundle between the latency controller, the TX/RX engines and the
// timestamp BRAM. The master side is the controller itself.
`timescale 1ns/1ps
interface bmd_256_latency_ctrl_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  latency_reset_signal;
  logic [63:0]           latency_counter;
  logic                  tx_pkt_sent;
  logic                  rx_pkt_rcvd;
  logic                  bram_wea;
  logic [DEPTH_LOG2-1:0] bram_wr_addr;
  logic [63:0]           bram_wr_data;
  logic                  bram_reb;
  logic [DEPTH_LOG2-1:0] bram_rd_addr;
  logic [63:0]           bram_rd_data;
  logic                  lat_valid;
  logic [63:0]           lat_last;
  logic [63:0]           lat_min;
  logic [63:0]           lat_max;
  logic [63:0]           lat_sum;
  logic [31:0]           lat_count;
  logic [DEPTH_LOG2:0]   outstanding;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    input  latency_reset_signal, latency_counter, tx_pkt_sent, rx_pkt_rcvd,
           bram_rd_data,
    output bram_wea, bram_wr_addr, bram_wr_data, bram_reb, bram_rd_addr,
           lat_valid, lat_last, lat_min, lat_max, lat_sum, lat_count,
           outstanding, overflow_err, underflow_err
  );

  modport slave (
    output latency_reset_signal, latency_counter, tx_pkt_sent, rx_pkt_rcvd,
           bram_rd_data,
    input  bram_wea, bram_wr_addr, bram_wr_data, bram_reb, bram_rd_addr,
           lat_valid, lat_last, lat_min, lat_max, lat_sum, lat_count,
           outstanding, overflow_err, underflow_err
  );
endinterface

// File: rtl/bmd_256_latency_ctrl.sv
// Timestamp FIFO sequencer over a 2-cycle-latency BRAM: writes a timestamp per
// sent packet, reads the oldest per received packet, and keeps latency stats.
`timescale 1ns/1ps
module bmd_256_latency_ctrl #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bmd_256_latency_ctrl_if.master bus
);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [63:0]         LAT_ALL_ONE = '1;

  logic                  clear;
  logic                  txAccept;
  logic                  rxAccept;
  logic [63:0]           latency;
  logic [64:0]           sumWide;

  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   outstanding_q, outstanding_d;
  logic                  wea_q, wea_d;
  logic [DEPTH_LOG2-1:0] wrAddr_q, wrAddr_d;
  logic [63:0]           wrData_q, wrData_d;
  logic                  reb_q, reb_d;
  logic [DEPTH_LOG2-1:0] rdAddr_q, rdAddr_d;
  logic [2:0]            arrValid_q, arrValid_d;
  logic [2:0][63:0]      arrTs_q, arrTs_d;
  logic                  latValid_q, latValid_d;
  logic [63:0]           latLast_q, latLast_d;
  logic [63:0]           latMin_q, latMin_d;
  logic [63:0]           latMax_q, latMax_d;
  logic [63:0]           latSum_q, latSum_d;
  logic [31:0]           latCount_q, latCount_d;
  logic                  ovfErr_q, ovfErr_d;
  logic                  unfErr_q, unfErr_d;

  assign clear = !rst_n || bus.latency_reset_signal;

  always_comb begin
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    outstanding_d = outstanding_q;
    wrAddr_d      = wrAddr_q;
    wrData_d      = wrData_q;
    rdAddr_d      = rdAddr_q;
    latLast_d     = latLast_q;
    latMin_d      = latMin_q;
    latMax_d      = latMax_q;
    latSum_d      = latSum_q;
    latCount_d    = latCount_q;
    ovfErr_d      = ovfErr_q;
    unfErr_d      = unfErr_q;

    // Full/empty decisions both use the count as it stood before this cycle
    txAccept   = bus.tx_pkt_sent && (outstanding_q != FULL_COUNT);
    rxAccept   = bus.rx_pkt_rcvd && (outstanding_q != '0);
    wea_d      = txAccept;
    reb_d      = rxAccept;
    latValid_d = arrValid_q[2];
    arrValid_d = {arrValid_q[1:0], rxAccept};
    arrTs_d    = {arrTs_q[1:0], bus.latency_counter};

    if (txAccept) begin
      wrAddr_d = wrPtr_q;
      wrData_d = bus.latency_counter;
      wrPtr_d  = wrPtr_q + DEPTH_LOG2'(1);
    end
    if (bus.tx_pkt_sent && !txAccept) ovfErr_d = 1'b1;

    if (rxAccept) begin
      rdAddr_d = rdPtr_q;
      rdPtr_d  = rdPtr_q + DEPTH_LOG2'(1);
    end
    if (bus.rx_pkt_rcvd && !rxAccept) unfErr_d = 1'b1;

    case ({txAccept, rxAccept})
      2'b10:   outstanding_d = outstanding_q + (DEPTH_LOG2+1)'(1);
      2'b01:   outstanding_d = outstanding_q - (DEPTH_LOG2+1)'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Modular difference keeps the result right across counter wrap
    latency = arrTs_q[2] - bus.bram_rd_data;
    sumWide = {1'b0, latSum_q} + {1'b0, latency};
    if (arrValid_q[2]) begin
      latLast_d  = latency;
      latMin_d   = (latency < latMin_q) ? latency : latMin_q;
      latMax_d   = (latency > latMax_q) ? latency : latMax_q;
      latSum_d   = sumWide[64] ? LAT_ALL_ONE : sumWide[63:0];
      latCount_d = (latCount_q == '1) ? latCount_q : latCount_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      outstanding_q <= '0;
      wea_q         <= 1'b0;
      wrAddr_q      <= '0;
      wrData_q      <= '0;
      reb_q         <= 1'b0;
      rdAddr_q      <= '0;
      arrValid_q    <= '0;
      arrTs_q       <= '0;
      latValid_q    <= 1'b0;
      latLast_q     <= '0;
      latMin_q      <= LAT_ALL_ONE;
      latMax_q      <= '0;
      latSum_q      <= '0;
      latCount_q    <= '0;
      ovfErr_q      <= 1'b0;
      unfErr_q      <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      outstanding_q <= outstanding_d;
      wea_q         <= wea_d;
      wrAddr_q      <= wrAddr_d;
      wrData_q      <= wrData_d;
      reb_q         <= reb_d;
      rdAddr_q      <= rdAddr_d;
      arrValid_q    <= arrValid_d;
      arrTs_q       <= arrTs_d;
      latValid_q    <= latValid_d;
      latLast_q     <= latLast_d;
      latMin_q      <= latMin_d;
      latMax_q      <= latMax_d;
      latSum_q      <= latSum_d;
      latCount_q    <= latCount_d;
      ovfErr_q      <= ovfErr_d;
      unfErr_q      <= unfErr_d;
    end
  end

  assign bus.bram_wea      = wea_q;
  assign bus.bram_wr_addr  = wrAddr_q;
  assign bus.bram_wr_data  = wrData_q;
  assign bus.bram_reb      = reb_q;
  assign bus.bram_rd_addr  = rdAddr_q;
  assign bus.lat_valid     = latValid_q;
  assign bus.lat_last      = latLast_q;
  assign bus.lat_min       = latMin_q;
  assign bus.lat_max       = latMax_q;
  assign bus.lat_sum       = latSum_q;
  assign bus.lat_count     = latCount_q;
  assign bus.outstanding   = outstanding_q;
  assign bus.overflow_err  = ovfErr_q;
  assign bus.underflow_err = unfErr_q;
endmodule

// File: tb/tb_bmd_256_latency_ctrl.sv
// Directed bench for bmd_256_latency_ctrl with a behavioural write-first,
// 2-cycle-read BRAM model; table vectors plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_bmd_256_latency_ctrl;
  localparam logic [2:0]  IDLE = 3'b000;
  localparam logic [2:0]  TX   = 3'b100;
  localparam logic [2:0]  RX   = 3'b010;
  localparam logic [2:0]  CLR  = 3'b001;
  localparam logic [63:0] M    = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic        wea;
    logic [9:0]  wrAddr;
    logic [63:0] wrData;
    logic        reb;
    logic [9:0]  rdAddr;
    logic        valid;
    logic [63:0] last;
    logic [63:0] mn;
    logic [63:0] mx;
    logic [63:0] sum;
    logic [31:0] count;
    logic [10:0] outst;
    logic        ovf;
    logic        unf;
  } outs_t;

  typedef struct {
    logic [2:0]  ctl;
    logic [63:0] cnt;
    outs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectorsApplied = 0;
  int   miscompares = 0;
  vec_t vecs[$];

  logic [63:0] mem [1024];
  logic [63:0] rd1, rd2;

  bmd_256_latency_ctrl_if #(.DEPTH_LOG2(10)) bus ();

  bmd_256_latency_ctrl #(.DEPTH_LOG2(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #2 clk = ~clk;

  // Timestamp BRAM: write-first, data appears two cycles after bram_reb
  always @(posedge clk) begin
    if (bus.bram_wea) mem[bus.bram_wr_addr] <= bus.bram_wr_data;
    if (bus.bram_reb)
      rd1 <= (bus.bram_wea && bus.bram_wr_addr == bus.bram_rd_addr) ?
             bus.bram_wr_data : mem[bus.bram_rd_addr];
    rd2 <= bus.latency_reset_signal ? 64'd0 : rd1;
  end
  assign bus.bram_rd_data = rd2;

  function automatic outs_t mkOut(
    input logic [63:0] wea, wrAddr, wrData, reb, rdAddr, valid,
    input logic [63:0] last, mn, mx, sum, count, outst, ovf, unf);
    outs_t o;
    o.wea = wea[0];       o.wrAddr = wrAddr[9:0]; o.wrData = wrData;
    o.reb = reb[0];       o.rdAddr = rdAddr[9:0]; o.valid = valid[0];
    o.last = last;        o.mn = mn;              o.mx = mx;
    o.sum = sum;          o.count = count[31:0];  o.outst = outst[10:0];
    o.ovf = ovf[0];       o.unf = unf[0];
    return o;
  endfunction

  function automatic void addVec(input logic [2:0] ctl, input logic [63:0] cnt,
                                 input outs_t e);
    vec_t v;
    v.ctl = ctl;
    v.cnt = cnt;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic int cmpField(input string tag, input string f,
                                  input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, f, act, exp);
      return 1;
    end
    return 0;
  endfunction

  task automatic applyStimulus(input logic [2:0] ctl, input logic [63:0] cnt);
    bus.tx_pkt_sent          = ctl[2];
    bus.rx_pkt_rcvd          = ctl[1];
    bus.latency_reset_signal = ctl[0];
    bus.latency_counter      = cnt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input outs_t e);
    int bad = 0;
    bad += cmpField(tag, "wea",    64'(bus.bram_wea),      64'(e.wea));
    bad += cmpField(tag, "wrAddr", 64'(bus.bram_wr_addr),  64'(e.wrAddr));
    bad += cmpField(tag, "wrData", bus.bram_wr_data,       e.wrData);
    bad += cmpField(tag, "reb",    64'(bus.bram_reb),      64'(e.reb));
    bad += cmpField(tag, "rdAddr", 64'(bus.bram_rd_addr),  64'(e.rdAddr));
    bad += cmpField(tag, "valid",  64'(bus.lat_valid),     64'(e.valid));
    bad += cmpField(tag, "last",   bus.lat_last,           e.last);
    bad += cmpField(tag, "min",    bus.lat_min,            e.mn);
    bad += cmpField(tag, "max",    bus.lat_max,            e.mx);
    bad += cmpField(tag, "sum",    bus.lat_sum,            e.sum);
    bad += cmpField(tag, "count",  64'(bus.lat_count),     64'(e.count));
    bad += cmpField(tag, "outst",  64'(bus.outstanding),   64'(e.outst));
    bad += cmpField(tag, "ovf",    64'(bus.overflow_err),  64'(e.ovf));
    bad += cmpField(tag, "unf",    64'(bus.underflow_err), 64'(e.unf));
    vectorsApplied++;
    if (bad != 0) miscompares++;
  endtask

  task automatic checkSig(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Single packet: ts 100 out, 350 back
    addVec(TX,   100, mkOut(1,0,100, 0,0,0,   0,  M,  0,  0,0, 1,0,0));
    addVec(IDLE,   0, mkOut(0,0,100, 0,0,0,   0,  M,  0,  0,0, 1,0,0));
    addVec(RX,   350, mkOut(0,0,100, 1,0,0,   0,  M,  0,  0,0, 0,0,0));
    addVec(IDLE,   0, mkOut(0,0,100, 0,0,0,   0,  M,  0,  0,0, 0,0,0));
    addVec(IDLE,   0, mkOut(0,0,100, 0,0,0,   0,  M,  0,  0,0, 0,0,0));
    addVec(IDLE,   0, mkOut(0,0,100, 0,0,1, 250,250,250,250,1, 0,0,0));
    addVec(IDLE,   0, mkOut(0,0,100, 0,0,0, 250,250,250,250,1, 0,0,0));
    addVec(CLR,    0, mkOut(0,0,  0, 0,0,0,   0,  M,  0,  0,0, 0,0,0));
    // Burst: four writes then four back-to-back reads
    addVec(TX,    10, mkOut(1,0, 10, 0,0,0,   0,  M,  0,  0,0, 1,0,0));
    addVec(TX,    20, mkOut(1,1, 20, 0,0,0,   0,  M,  0,  0,0, 2,0,0));
    addVec(TX,    30, mkOut(1,2, 30, 0,0,0,   0,  M,  0,  0,0, 3,0,0));
    addVec(TX,    40, mkOut(1,3, 40, 0,0,0,   0,  M,  0,  0,0, 4,0,0));
    addVec(RX,   110, mkOut(0,3, 40, 1,0,0,   0,  M,  0,  0,0, 3,0,0));
    addVec(RX,   125, mkOut(0,3, 40, 1,1,0,   0,  M,  0,  0,0, 2,0,0));
    addVec(RX,   140, mkOut(0,3, 40, 1,2,0,   0,  M,  0,  0,0, 1,0,0));
    addVec(RX,   160, mkOut(0,3, 40, 1,3,1, 100,100,100,100,1, 0,0,0));
    addVec(IDLE,   0, mkOut(0,3, 40, 0,3,1, 105,100,105,205,2, 0,0,0));
    addVec(IDLE,   0, mkOut(0,3, 40, 0,3,1, 110,100,110,315,3, 0,0,0));
    addVec(IDLE,   0, mkOut(0,3, 40, 0,3,1, 120,100,120,435,4, 0,0,0));
    addVec(IDLE,   0, mkOut(0,3, 40, 0,3,0, 120,100,120,435,4, 0,0,0));

    rst_n = 1'b0;
    bus.tx_pkt_sent = 1'b0;
    bus.rx_pkt_rcvd = 1'b0;
    bus.latency_reset_signal = 1'b0;
    bus.latency_counter = '0;
    @(negedge clk);
    repeat (3) applyStimulus(IDLE, 0);
    rst_n = 1'b1;
    checkOutput("reset", mkOut(0,0,0, 0,0,0, 0,M,0,0,0, 0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ctl, vecs[i].cnt);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Counter wrap: 10 - (2^64-5) = 15
    applyStimulus(CLR, 0);
    applyStimulus(TX, 64'hFFFF_FFFF_FFFF_FFFB);
    applyStimulus(IDLE, 0);
    applyStimulus(RX, 10);
    repeat (2) applyStimulus(IDLE, 0);
    checkSig("wrap.validEarly", 64'(bus.lat_valid), 0);
    applyStimulus(IDLE, 0);
    checkSig("wrap.valid", 64'(bus.lat_valid), 1);
    checkSig("wrap.last", bus.lat_last, 15);

    // Empty: underflow, no read, no sample
    applyStimulus(RX, 5);
    checkSig("empty.unf", 64'(bus.underflow_err), 1);
    checkSig("empty.reb", 64'(bus.bram_reb), 0);
    repeat (3) applyStimulus(IDLE, 0);
    checkSig("empty.noValid", 64'(bus.lat_valid), 0);
    checkSig("empty.count", 64'(bus.lat_count), 1);
    applyStimulus(CLR, 0);
    applyStimulus(TX | RX, 7);
    checkSig("empty.both.wea", 64'(bus.bram_wea), 1);
    checkSig("empty.both.data", bus.bram_wr_data, 7);
    checkSig("empty.both.reb", 64'(bus.bram_reb), 0);
    checkSig("empty.both.unf", 64'(bus.underflow_err), 1);
    checkSig("empty.both.outst", 64'(bus.outstanding), 1);

    // Full and pointer wrap
    applyStimulus(CLR, 0);
    for (int i = 0; i < 1024; i++) applyStimulus(TX, 64'(i));
    checkSig("full.outst", 64'(bus.outstanding), 1024);
    checkSig("full.ovfClear", 64'(bus.overflow_err), 0);
    checkSig("full.lastAddr", 64'(bus.bram_wr_addr), 1023);
    applyStimulus(TX, 9999);
    checkSig("full.drop.wea", 64'(bus.bram_wea), 0);
    checkSig("full.drop.ovf", 64'(bus.overflow_err), 1);
    checkSig("full.drop.outst", 64'(bus.outstanding), 1024);
    applyStimulus(RX, 5000);
    checkSig("full.rd.reb", 64'(bus.bram_reb), 1);
    checkSig("full.rd.addr", 64'(bus.bram_rd_addr), 0);
    checkSig("full.rd.outst", 64'(bus.outstanding), 1023);
    applyStimulus(TX, 6000);
    checkSig("full.wrap.wea", 64'(bus.bram_wea), 1);
    checkSig("full.wrap.addr", 64'(bus.bram_wr_addr), 0);
    checkSig("full.wrap.outst", 64'(bus.outstanding), 1024);
    repeat (2) applyStimulus(IDLE, 0);
    checkSig("full.sample.valid", 64'(bus.lat_valid), 1);
    checkSig("full.sample.last", bus.lat_last, 5000);

    // Clear one cycle after an accepted read: the sample must vanish
    applyStimulus(CLR, 0);
    applyStimulus(RX, 0);
    checkSig("clr.preUnf", 64'(bus.underflow_err), 1);
    applyStimulus(TX, 20);
    applyStimulus(IDLE, 0);
    applyStimulus(RX, 90);
    applyStimulus(TX | RX | CLR, 0);
    checkOutput("clr.state", mkOut(0,0,0, 0,0,0, 0,M,0,0,0, 0,0,0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(IDLE, 0);
      checkSig($sformatf("clr.noValid%0d", i), 64'(bus.lat_valid), 0);
    end
    checkSig("clr.min", bus.lat_min, M);
    checkSig("clr.outst", 64'(bus.outstanding), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end
endmodule

// File: doc/bmd_256_latency_ctrl.md
# bmd_256_latency_ctrl

Sequencing controller for the 1024-deep latency-timestamp BRAM in the BMD 256-bit PCIe path. It writes a 64-bit timestamp on every packet the TX engine sends and reads the oldest timestamp back on every packet the RX engine receives. From each read it computes the per-packet latency and running statistics. It sits between TX_ENGINE/RX_ENGINE and the timestamp BRAM, which is simple dual-port, write-first, with 2-cycle port-B read latency.

## Interface
- DEPTH_LOG2, 10, BRAM address width; depth 2^DEPTH_LOG2 entries.
- clk  in  1  250 MHz clock, shared with the BRAM.
- rst_n  in  1  synchronous, active-low reset.
- latency_reset_signal  in  1  user clear (from RX_ENGINE); synchronous, same effect as rst_n on this block; also drives the BRAM rstb.
- latency_counter  in  64  free-running timestamp counter.
- tx_pkt_sent  in  1  one-cycle pulse per packet sent.
- rx_pkt_rcvd  in  1  one-cycle pulse per packet received; packets return in order.
- bram_wea  out  1  BRAM write enable.
- bram_wr_addr  out  10  BRAM write address.
- bram_wr_data  out  64  timestamp to write.
- bram_reb  out  1  BRAM read enable.
- bram_rd_addr  out  10  BRAM read address.
- bram_rd_data  in  64  BRAM read data, valid 2 cycles after bram_reb.
- lat_valid  out  1  one-cycle pulse when lat_last is updated.
- lat_last  out  64  most recent latency in clk cycles.
- lat_min / lat_max  out  64  extreme latencies since clear.
- lat_sum  out  64  saturating sum of latencies.
- lat_count  out  32  saturating number of samples.
- outstanding  out  11  timestamps written but not yet read (0..1024).
- overflow_err / underflow_err  out  1  sticky error flags.

## Operation
- Pointers: wr_ptr and rd_ptr are 10-bit and wrap 1023→0. outstanding is tracked as an 11-bit count.
- TX accept: on tx_pkt_sent with outstanding<1024:
  - next cycle, bram_wea=1, bram_wr_addr=wr_ptr, bram_wr_data=latency_counter sampled in the pulse cycle;
  - wr_ptr then increments.
- TX drop: on tx_pkt_sent with outstanding==1024, no write occurs, overflow_err is set, and the pointers are unchanged.
- RX accept: on rx_pkt_rcvd with outstanding>0:
  - next cycle, bram_reb=1, bram_rd_addr=rd_ptr;
  - rd_ptr then increments;
  - latency_counter sampled in the pulse cycle is carried down a 3-stage arrival pipeline aligned with the read.
- RX drop: on rx_pkt_rcvd with outstanding==0, no read occurs and underflow_err is set.
- Full/empty tests use outstanding as registered before the current cycle's update.
- Same-cycle TX and RX:
  - both are evaluated independently against the pre-update count;
  - if both are accepted, outstanding is unchanged;
  - when outstanding==0, the RX pulse is an underflow even if TX is accepted in the same cycle.
- Latency arithmetic: lat = arrival_ts − bram_rd_data, as 64-bit modular subtraction, so counter wrap is tolerated.
- Statistics on each sample:
  - lat_last=lat;
  - lat_min=min(lat_min, lat);
  - lat_max=max(lat_max, lat);
  - lat_sum=lat_sum+lat, saturating at 2^64−1;
  - lat_count+1, saturating at 2^32−1.
- Back-to-back RX pulses on consecutive cycles are fully pipelined: one sample per cycle, no stall.
- Clear (rst_n low or latency_reset_signal high):
  - pointers, outstanding, lat_last, lat_max, lat_sum, lat_count, both error flags, bram_wea, bram_reb, lat_valid → 0;
  - lat_min → 2^64−1;
  - the in-flight read pipeline is flushed, so no lat_valid is produced for reads issued before the clear;
  - pulses arriving during clear are ignored.

## Timing
- All outputs are registered. Reset values are as listed under Clear; bram_wr_addr, bram_rd_addr and bram_wr_data reset to 0.
- TX pulse at cycle T: bram_wea at T+1; outstanding updated at T+1.
- RX pulse at cycle T:
  - bram_reb at T+1;
  - bram_rd_data valid at T+3;
  - lat_valid and all statistics updated at T+4.
- Measured latency excludes the controller's own pipeline, because the arrival timestamp is captured at T.
- Statistics registers change only in a lat_valid cycle or on clear.
- Error flags are sticky until clear.

## Test plan
- Single packet: tx_pkt_sent with counter=100, rx_pkt_rcvd with counter=350 → bram_wr_addr=0 and data=100; lat_valid 4 cycles after the RX pulse; lat_last=min=max=sum=250; count=1; outstanding returns to 0.
- Burst of 4 TX then 4 back-to-back RX, with TX counters 10,20,30,40 and RX counters 110,125,140,160 → four consecutive lat_valid pulses with lat_last=100,105,110,120; min=100; max=120; sum=435.
- Full/wrap: 1024 TX with no RX → outstanding=1024. A 1025th TX → overflow_err=1 and no bram_wea. One RX then one TX → the new write goes to address 0 and outstanding=1024.
- Empty: RX with outstanding=0 → underflow_err=1, no bram_reb, no lat_valid. TX and RX in the same cycle at empty → write occurs, underflow_err=1, outstanding=1.
- Counter wrap: TX at counter 2^64−5, RX at counter 10 → lat_last=15.
- Clear mid-read: assert latency_reset_signal one cycle after an accepted RX pulse → no lat_valid; lat_min=2^64−1; pointers and outstanding=0; errors cleared.
